// File: rtl/alu_pkg.sv
// Shared encodings for the ALU decoder: ALUOp classes, ALUControl selects
// and the funct3 values recognised under the funct-decoded op class.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUCTL_ADD = 3'b000;
  localparam logic [2:0] ALUCTL_SUB = 3'b001;
  localparam logic [2:0] ALUCTL_AND = 3'b010;
  localparam logic [2:0] ALUCTL_OR  = 3'b011;
  localparam logic [2:0] ALUCTL_XOR = 3'b100;
  localparam logic [2:0] ALUCTL_SLT = 3'b101;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  // A subtract under the funct class needs both an R-type opcode and funct7[5];
  // ADDI can carry funct7[5]=1 in its immediate and must stay an add.
  function automatic logic is_sub(input logic op5, input logic funct7_5);
    return op5 & funct7_5;
  endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// Purely combinational ALU decode: ALUOp class plus funct fields to the next
// ALUControl select, with a flag for encodings this ALU does not implement.
module alu_decode_comb
  import alu_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op5,
  output logic [2:0] next_ctl,
  output logic       next_illegal
);

  // Unsupported encodings fall back to ADD so the ALU never sees a reserved code.
  always_comb begin
    next_ctl     = ALUCTL_ADD;
    next_illegal = 1'b0;
    case (ALUOp)
      ALUOP_ADD: next_ctl = ALUCTL_ADD;
      ALUOP_SUB: next_ctl = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          F3_ADDSUB: next_ctl = is_sub(op5, funct7_5) ? ALUCTL_SUB : ALUCTL_ADD;
          F3_SLT:    next_ctl = ALUCTL_SLT;
          F3_XOR:    next_ctl = ALUCTL_XOR;
          F3_OR:     next_ctl = ALUCTL_OR;
          F3_AND:    next_ctl = ALUCTL_AND;
          default: begin
            next_ctl     = ALUCTL_ADD;
            next_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        next_ctl     = ALUCTL_ADD;
        next_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_decoder.sv
// ALU decoder top: registers the combinational decode so ALUControl and
// illegal line up with the execute-stage boundary, one cycle after the inputs.
module alu_decoder
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic [6:0] op,
  output logic [2:0] ALUControl,
  output logic       illegal
);

  logic [2:0] next_ctl;
  logic       next_illegal;

  // Only bit 5 of funct7 and op steer the decode; the rest are deliberately dropped.
  logic unused_fields;
  assign unused_fields = ^{funct7[6], funct7[4:0], op[6], op[4:0]};

  alu_decode_comb u_decode (
    .ALUOp        (ALUOp),
    .funct3       (funct3),
    .funct7_5     (funct7[5]),
    .op5          (op[5]),
    .next_ctl     (next_ctl),
    .next_illegal (next_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ALUControl <= ALUCTL_ADD;
      illegal    <= 1'b0;
    end else begin
      ALUControl <= next_ctl;
      illegal    <= next_illegal;
    end
  end

endmodule

// File: tb/tb_alu_decoder.sv
// Directed bench for alu_decoder: hand-computed vectors checked one cycle
// after they are driven, plus reset timing and mid-cycle input changes.
module tb_alu_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ALUOp;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [6:0] op;
  logic [2:0] ALUControl;
  logic       illegal;

  int vectors = 0;
  int miscompares = 0;

  alu_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .ALUOp      (ALUOp),
    .funct3     (funct3),
    .funct7     (funct7),
    .op         (op),
    .ALUControl (ALUControl),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] a, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [6:0] o);
    ALUOp  = a;
    funct3 = f3;
    funct7 = f7;
    op     = o;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] expCtl, input logic expIll);
    vectors++;
    assert ({ALUControl, illegal} === {expCtl, expIll})
    else begin
      miscompares++;
      $error("[TB] FAIL %s: ALUControl=%b illegal=%b, expected ALUControl=%b illegal=%b",
             tag, ALUControl, illegal, expCtl, expIll);
    end
  endtask

  initial begin
    // Reset held for two edges while the inputs would otherwise decode to OR.
    rst = 1'b1;
    applyStimulus(2'b10, 3'b110, 7'b1000000, 7'b1000000);
    tick();
    checkOutput("reset_edge1", 3'b000, 1'b0);
    tick();
    checkOutput("reset_edge2", 3'b000, 1'b0);
    rst = 1'b0;
    tick();
    checkOutput("post_reset_or", 3'b011, 1'b0);

    // ALUOp=00/01 ignore the funct fields.
    applyStimulus(2'b00, 3'b000, 7'b1000000, 7'b1000000); tick(); checkOutput("aluop00_f3_000", 3'b000, 1'b0);
    applyStimulus(2'b00, 3'b010, 7'b1000000, 7'b1000000); tick(); checkOutput("aluop00_f3_010", 3'b000, 1'b0);
    applyStimulus(2'b00, 3'b110, 7'b1000000, 7'b1000000); tick(); checkOutput("aluop00_f3_110", 3'b000, 1'b0);
    applyStimulus(2'b00, 3'b111, 7'b1000000, 7'b1000000); tick(); checkOutput("aluop00_f3_111", 3'b000, 1'b0);
    applyStimulus(2'b01, 3'b111, 7'b0100000, 7'b0100000); tick(); checkOutput("aluop01_sub",    3'b001, 1'b0);

    // Funct-decoded class with bit 5 of funct7/op clear.
    applyStimulus(2'b10, 3'b000, 7'b1000000, 7'b1000000); tick(); checkOutput("f3_000_add", 3'b000, 1'b0);
    applyStimulus(2'b10, 3'b010, 7'b1000000, 7'b1000000); tick(); checkOutput("f3_010_slt", 3'b101, 1'b0);
    applyStimulus(2'b10, 3'b110, 7'b1000000, 7'b1000000); tick(); checkOutput("f3_110_or",  3'b011, 1'b0);
    applyStimulus(2'b10, 3'b111, 7'b1000000, 7'b1000000); tick(); checkOutput("f3_111_and", 3'b010, 1'b0);
    applyStimulus(2'b10, 3'b100, 7'b1000000, 7'b1000000); tick(); checkOutput("f3_100_xor", 3'b100, 1'b0);

    // ADD/SUB selection by {op[5], funct7[5]}, other bits set to show they are ignored.
    applyStimulus(2'b10, 3'b000, 7'b0100000, 7'b0110011); tick(); checkOutput("addsub_11", 3'b001, 1'b0);
    applyStimulus(2'b10, 3'b000, 7'b1011111, 7'b0110011); tick(); checkOutput("addsub_10", 3'b000, 1'b0);
    applyStimulus(2'b10, 3'b000, 7'b0100000, 7'b0010011); tick(); checkOutput("addsub_01", 3'b000, 1'b0);
    applyStimulus(2'b10, 3'b000, 7'b0000000, 7'b0000000); tick(); checkOutput("addsub_00", 3'b000, 1'b0);

    // Unsupported encodings: ADD with illegal raised.
    applyStimulus(2'b10, 3'b001, 7'b0000000, 7'b0110011); tick(); checkOutput("illegal_f3_001", 3'b000, 1'b1);
    applyStimulus(2'b10, 3'b011, 7'b0000000, 7'b0110011); tick(); checkOutput("illegal_f3_011", 3'b000, 1'b1);
    applyStimulus(2'b10, 3'b101, 7'b0100000, 7'b0110011); tick(); checkOutput("illegal_f3_101", 3'b000, 1'b1);
    applyStimulus(2'b11, 3'b000, 7'b0100000, 7'b0100000); tick(); checkOutput("illegal_op11_a", 3'b000, 1'b1);
    applyStimulus(2'b11, 3'b110, 7'b0000000, 7'b0000000); tick(); checkOutput("illegal_op11_b", 3'b000, 1'b1);

    // Back to a legal encoding clears illegal.
    applyStimulus(2'b10, 3'b110, 7'b0000000, 7'b0110011); tick(); checkOutput("legal_after_illegal", 3'b011, 1'b0);

    // Mid-cycle input change is invisible until the next edge.
    #1;
    applyStimulus(2'b10, 3'b111, 7'b0000000, 7'b0110011);
    #3;
    checkOutput("hold_before_edge", 3'b011, 1'b0);
    tick();
    checkOutput("update_after_edge", 3'b010, 1'b0);

    // Reset sampled high mid-stream clears outputs on that edge.
    rst = 1'b1;
    tick();
    checkOutput("midstream_reset", 3'b000, 1'b0);
    rst = 1'b0;
    tick();
    checkOutput("after_midstream_reset", 3'b010, 1'b0);

    // A reset pulse that drops before the edge is never sampled.
    #1;
    rst = 1'b1;
    applyStimulus(2'b10, 3'b100, 7'b0000000, 7'b0110011);
    #2;
    checkOutput("rst_glitch_no_async", 3'b010, 1'b0);
    #2;
    rst = 1'b0;
    tick();
    checkOutput("rst_glitch_unsampled", 3'b100, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
